// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: one shared period counter, per-channel duty compare, shadowed updates at period boundaries.
// Optional center-aligned counting is enabled with `define PWM_CENTER_ALIGNED_EN.
module pwm_multichannel #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      load,
`ifdef PWM_CENTER_ALIGNED_EN
    input  logic                      center,
`endif
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_end,
    output logic                      upd_pending,
    output logic                      status
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] p_a;
    logic [WIDTH-1:0] p_p;
    logic [WIDTH-1:0] d_a [CHANNELS];
    logic [WIDTH-1:0] d_p [CHANNELS];

    logic boundary_c;
    logic apply_in_c;
    logic apply_pend_c;
    logic capture_c;

`ifdef PWM_CENTER_ALIGNED_EN
    logic             center_a;
    logic             center_p;
    logic             dir_down;
    logic [WIDTH-1:0] top_c;

    // Turn-around point of the up/down count; a zero period behaves as one.
    always_comb begin
        top_c      = (p_a == '0) ? '0 : p_a - WIDTH'(1);
        boundary_c = center_a ? (dir_down && (cnt == '0)) : (cnt == p_a);
    end
`else
    always_comb begin
        boundary_c = (cnt == p_a);
    end
`endif

    // Disabled means no period is in flight, so updates take effect at once.
    always_comb begin
        apply_in_c   = load && (!en || boundary_c);
        apply_pend_c = !apply_in_c && upd_pending && (!en || boundary_c);
        capture_c    = load && en && !boundary_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            p_a         <= '1;
            p_p         <= '1;
            pwm_out     <= '0;
            period_end  <= 1'b0;
            upd_pending <= 1'b0;
            status      <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                d_a[i] <= '0;
                d_p[i] <= '0;
            end
`ifdef PWM_CENTER_ALIGNED_EN
            center_a <= 1'b0;
            center_p <= 1'b0;
            dir_down <= 1'b0;
`endif
        end else begin
            status <= en;

            if (apply_in_c) begin
                p_a <= period;
                for (int i = 0; i < CHANNELS; i++) d_a[i] <= duty[i*WIDTH +: WIDTH];
`ifdef PWM_CENTER_ALIGNED_EN
                center_a <= center;
`endif
            end else if (apply_pend_c) begin
                p_a <= p_p;
                for (int i = 0; i < CHANNELS; i++) d_a[i] <= d_p[i];
`ifdef PWM_CENTER_ALIGNED_EN
                center_a <= center_p;
`endif
            end

            if (capture_c) begin
                p_p <= period;
                for (int i = 0; i < CHANNELS; i++) d_p[i] <= duty[i*WIDTH +: WIDTH];
`ifdef PWM_CENTER_ALIGNED_EN
                center_p <= center;
`endif
                upd_pending <= 1'b1;
            end else if (apply_in_c || apply_pend_c) begin
                upd_pending <= 1'b0;
            end

            if (!en) begin
                cnt        <= '0;
                pwm_out    <= '0;
                period_end <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
                dir_down   <= 1'b0;
`endif
            end else begin
                period_end <= boundary_c;
                for (int i = 0; i < CHANNELS; i++) pwm_out[i] <= (cnt < d_a[i]);
                if (boundary_c) begin
                    cnt <= '0;
`ifdef PWM_CENTER_ALIGNED_EN
                    dir_down <= 1'b0;
`endif
                end else begin
`ifdef PWM_CENTER_ALIGNED_EN
                    // Each endpoint is held for two cycles: direction flips without moving cnt.
                    if (!center_a)           cnt <= cnt + WIDTH'(1);
                    else if (dir_down)       cnt <= cnt - WIDTH'(1);
                    else if (cnt == top_c)   dir_down <= 1'b1;
                    else                     cnt <= cnt + WIDTH'(1);
`else
                    cnt <= cnt + WIDTH'(1);
`endif
                end
            end
        end
    end

endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised multi-channel PWM generator: one shared period counter drives `CHANNELS` independent duty-cycle comparators with glitch-free shadow-register updates at period boundaries. It is the next-generation replacement for the fixed 8-bit, fixed-threshold PWM block in the FPGA top level. Period and duty are runtime-programmable, and an optional center-aligned mode is available.

## Interface
- `WIDTH`, default 8: counter, period and duty width in bits.
- `CHANNELS`, default 4: number of PWM outputs.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  1  run enable.
- `period`  in  WIDTH  period setting P; captured on `load`.
- `duty`  in  CHANNELS*WIDTH  duty D[i] = `duty[i*WIDTH +: WIDTH]`; captured on `load`.
- `load`  in  1  single-cycle strobe; captures `period`, `duty` (and `center`) into pending registers.
- `pwm_out`  out  CHANNELS  registered PWM outputs.
- `period_end`  out  1  registered one-cycle pulse on the last cycle of each PWM period.
- `upd_pending`  out  1  pending settings not yet applied.
- `status`  out  1  registered; 1 while running (`en`=1, not in reset).

## Operation
- Registers:
  - counter `cnt`;
  - active copies `P_a`, `D_a[i]`;
  - pending copies `P_p`, `D_p[i]`;
  - pending flag;
  - direction bit (center mode only).
- Edge-aligned counting: `cnt` runs 0,1,…,P_a, then wraps to 0. Period = P_a+1 cycles. The boundary cycle is `cnt`==P_a.
- Compare: `pwm_out[i]` next = (`cnt` < `D_a[i]`), giving D high cycles per period.
  - D=0: output constantly low.
  - D>P_a: output constantly high.
- P_a=0: `cnt` stays 0, every cycle is a boundary, outputs are high iff D≥1.
- `load` behaviour:
  - Copies inputs to the pending registers and sets `upd_pending`.
  - A second `load` before apply overwrites the pending values; the last one wins.
- Apply:
  - On a boundary cycle with `upd_pending`=1, the pending values are copied to active.
  - `cnt` then restarts at 0 under the new P_a.
  - `upd_pending` clears.
- `load` asserted on a boundary cycle bypasses pending: the new inputs become active at that same boundary.
- `en`=0:
  - `cnt` is forced to 0 and the direction is set to up.
  - `pwm_out`=0, `period_end`=0, `status`=0.
  - Pending values are applied immediately, since no period is in flight.
- `en` rising: counting starts from `cnt`=0 with the active settings.
- Arithmetic: compares are unsigned WIDTH-bit, and the counter never exceeds P_a.

## Timing
- Reset values: `cnt`=0, P_a=P_p=all ones, `D_a`=`D_p`=0, `pwm_out`=0, `period_end`=0, `upd_pending`=0, `status`=0, direction=up.
- Latency:
  - `pwm_out` and `period_end` are one cycle behind the `cnt` value they are derived from.
  - `status` follows `en` with 1 cycle of latency.
- First output after `en` rises: `pwm_out` is valid 1 cycle after the first counted cycle.
- Apply latency: new settings are active on the cycle after the boundary, and the first output with the new duty appears 2 cycles after the boundary.
- `upd_pending`: rises the cycle after `load`, falls the cycle after apply.
- `rst` mid-period: all state returns to reset values on the next edge, including pending settings and any in-flight `load`.

## Configuration
- Macro: `PWM_CENTER_ALIGNED_EN`.
- With the macro defined:
  - Adds input `center` (1 bit), captured and applied with `period`/`duty`.
  - When active `center`=1, `cnt` runs 0,1,…,P_a−1, then P_a−1,…,0. Each endpoint is held twice.
  - Period = 2·P_a cycles; P_a=0 is treated as 1.
  - The boundary cycle is `cnt`==0 while counting down.
  - Compare is unchanged, giving 2·D high cycles symmetric about the period centre.
- Without the macro: no `center` port, no direction bit, edge-aligned only.

## Test plan
- WIDTH=8, CHANNELS=4: `rst` 3 cycles, P=99, D={50,0,100,255}, `load`, `en`=1.
  - ch0: 50 high / 50 low, period 100.
  - ch1: always low.
  - ch2 and ch3: always high.
  - `period_end` pulses every 100 cycles.
- Running P=9, D0=3. Pulse `load` with D0=7 at `cnt`=4.
  - Current period finishes with 3 high cycles.
  - `upd_pending`=1 until the boundary.
  - Next period has 7 high cycles.
- `load` on the exact boundary cycle (`cnt`==P): new values are applied at that boundary, and `upd_pending` never asserts.
- Assert `rst` for 1 cycle mid-period with D0=5: next cycle `pwm_out`=0, `status`=0, and the pending load is discarded.
- P=0, D0=1, `en` toggled low for 5 cycles, then high:
  - Constant high while running.
  - 0 while disabled.
  - `period_end` high every running cycle.
- `PWM_CENTER_ALIGNED_EN`, `center`=1, P=4, D0=2:
  - Count sequence 0,1,2,3,3,2,1,0.
  - `pwm_out[0]` pattern 1,1,0,0,0,0,1,1.
  - `period_end` on the final 0.
